// File: rtl/lcd_timing_gen_pkg.sv
// lcd_timing_gen_pkg: shared types and constants for the LCD timing generator.
// Holds the run/stop FSM encoding, the colour-bar palette used when the
// TEST_PATTERN_EN build macro is defined, and a period-total helper.
package lcd_timing_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STOP_PEND = 2'd2
    } lcd_state_e;

    // Bar colour as {red_on, green_on, blue_on}; expanded to full field width later.
    typedef logic [2:0] bar_rgb_t;

    localparam bar_rgb_t BAR_WHITE   = 3'b111;
    localparam bar_rgb_t BAR_YELLOW  = 3'b110;
    localparam bar_rgb_t BAR_CYAN    = 3'b011;
    localparam bar_rgb_t BAR_GREEN   = 3'b010;
    localparam bar_rgb_t BAR_MAGENTA = 3'b101;
    localparam bar_rgb_t BAR_RED     = 3'b100;
    localparam bar_rgb_t BAR_BLUE    = 3'b001;
    localparam bar_rgb_t BAR_BLACK   = 3'b000;

    localparam int NUM_BARS = 8;

    // Total period of one line or one frame (sync + back porch + active + front porch).
    function automatic int period_total(input int sync_len, input int bp_len,
                                        input int act_len, input int fp_len);
        return sync_len + bp_len + act_len + fp_len;
    endfunction

    // Bar order left to right: W, Y, C, G, M, R, B, K.
    function automatic bar_rgb_t bar_colour(input logic [2:0] idx);
        bar_rgb_t c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_timing_gen_pattern.sv
// lcd_pattern_gen: eight vertical colour bars across the active width.
// Bars are H_ACTIVE/8 pixels wide; the last bar absorbs any remainder.
module lcd_pattern_gen
    import lcd_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = 480,
    parameter int R_W      = 5,
    parameter int G_W      = 6,
    parameter int B_W      = 5
) (
    input  logic [15:0]              x,
    output logic [R_W+G_W+B_W-1:0]   colour
);

    localparam int          BAR_PX   = (H_ACTIVE / NUM_BARS > 0) ? H_ACTIVE / NUM_BARS : 1;
    localparam logic [15:0] BAR_PX_L = 16'(BAR_PX);

    logic [15:0] bar_q;
    logic [2:0]  bar_idx;
    bar_rgb_t    bar_on;

    // Map column to bar index (clamped to the last bar) and expand to field widths.
    always_comb begin
        bar_q   = x / BAR_PX_L;
        bar_idx = (bar_q > 16'd7) ? 3'd7 : bar_q[2:0];
        bar_on  = bar_colour(bar_idx);
        colour  = {{R_W{bar_on[2]}}, {G_W{bar_on[1]}}, {B_W{bar_on[0]}}};
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: RGB-parallel LCD timing generator.
// Counters, run/stop FSM and registered panel pins; pixels are requested one
// cycle ahead of DE. Build macro TEST_PATTERN_EN adds tp_sel and a colour-bar source.
module lcd_timing_gen
    import lcd_timing_gen_pkg::*;
#(
    parameter int   H_SYNC   = 10,
    parameter int   H_BP     = 40,
    parameter int   H_ACTIVE = 480,
    parameter int   H_FP     = 8,
    parameter int   V_SYNC   = 11,
    parameter int   V_BP     = 1,
    parameter int   V_ACTIVE = 272,
    parameter int   V_FP     = 8,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter logic DE_POL   = 1'b1,
    parameter int   R_W      = 5,
    parameter int   G_W      = 6,
    parameter int   B_W      = 5,
    parameter logic [R_W+G_W+B_W-1:0] UNDERFLOW_RGB = '0
) (
    input  logic                     PixelClk,
    input  logic                     RST,
    input  logic                     en,
    input  logic [R_W+G_W+B_W-1:0]   pix_data,
    input  logic                     pix_valid,
`ifdef TEST_PATTERN_EN
    input  logic                     tp_sel,
`endif
    output logic                     pix_req,
    output logic [15:0]              pix_x,
    output logic [15:0]              pix_y,
    output logic                     frame_start,
    input  logic                     underflow_clr,
    output logic                     underflow,
    output logic                     running,
    output logic                     LCD_DE,
    output logic                     LCD_HSYNC,
    output logic                     LCD_VSYNC,
    output logic [R_W-1:0]           LCD_R,
    output logic [G_W-1:0]           LCD_G,
    output logic [B_W-1:0]           LCD_B
);

    localparam int PIX_W = R_W + G_W + B_W;
    localparam int H_TOT = period_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOT = period_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

    localparam logic [15:0] H_SYNC_END = 16'(H_SYNC);
    localparam logic [15:0] H_ACT_BEG  = 16'(H_SYNC + H_BP);
    localparam logic [15:0] H_ACT_END  = 16'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [15:0] H_LAST     = 16'(H_TOT - 1);
    localparam logic [15:0] V_SYNC_END = 16'(V_SYNC);
    localparam logic [15:0] V_ACT_BEG  = 16'(V_SYNC + V_BP);
    localparam logic [15:0] V_ACT_END  = 16'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [15:0] V_LAST     = 16'(V_TOT - 1);

    lcd_state_e       state_q, state_d;
    logic [15:0]      h_cnt_q, h_cnt_d;
    logic [15:0]      v_cnt_q, v_cnt_d;
    logic             de_q, de_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic [PIX_W-1:0] rgb_q, rgb_d;
    logic             underflow_q, underflow_d;

    logic             run_w;
    logic             active_w;
    logic             last_px_w;
    logic [PIX_W-1:0] src_data;
    logic             src_ok;

    // Decode position: active window, last pixel of frame, frame start, request coordinates.
    always_comb begin
        run_w       = (state_q != ST_IDLE);
        active_w    = run_w
                      && (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END)
                      && (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
        last_px_w   = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
        frame_start = run_w && (h_cnt_q == '0) && (v_cnt_q == '0);
        running     = run_w;
        pix_x       = '0;
        pix_y       = '0;
        if (active_w) begin
            pix_x = h_cnt_q - H_ACT_BEG;
            pix_y = v_cnt_q - V_ACT_BEG;
        end
    end

`ifdef TEST_PATTERN_EN
    logic             tp_q, tp_d;
    logic [PIX_W-1:0] bar_rgb;

    lcd_pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .R_W      (R_W),
        .G_W      (G_W),
        .B_W      (B_W)
    ) u_pattern (
        .x      (pix_x),
        .colour (bar_rgb)
    );

    // Pixel source select; tp_sel is latched only at frame_start so no frame is mixed.
    always_comb begin
        tp_d     = frame_start ? tp_sel : tp_q;
        pix_req  = active_w & ~tp_q;
        src_data = tp_q ? bar_rgb : pix_data;
        src_ok   = tp_q | pix_valid;
    end

    // Pattern select register.
    always_ff @(posedge PixelClk) begin
        if (RST) tp_q <= 1'b0;
        else     tp_q <= tp_d;
    end
`else
    // Pixel source is always the upstream pix_data stream.
    always_comb begin
        pix_req  = active_w;
        src_data = pix_data;
        src_ok   = pix_valid;
    end
`endif

    // Run/stop FSM: a stop request only takes effect once the current frame ends.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (en) state_d = ST_RUN;
            ST_RUN:       if (!en) state_d = ST_STOP_PEND;
            ST_STOP_PEND: begin
                if (en)             state_d = ST_RUN;
                else if (last_px_w) state_d = ST_IDLE;
            end
            default:      state_d = ST_IDLE;
        endcase
    end

    // Horizontal/vertical counters; held at zero while idle.
    always_comb begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (run_w) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 16'd1;
            end else begin
                h_cnt_d = h_cnt_q + 16'd1;
                v_cnt_d = v_cnt_q;
            end
        end
    end

    // Next pin values for the request cycle, plus sticky underflow (set beats clear).
    always_comb begin
        de_d = active_w ? DE_POL : ~DE_POL;
        hs_d = (run_w && (h_cnt_q < H_SYNC_END)) ? HS_POL : ~HS_POL;
        vs_d = (run_w && (v_cnt_q < V_SYNC_END)) ? VS_POL : ~VS_POL;
        rgb_d = '0;
        if (active_w) rgb_d = src_ok ? src_data : UNDERFLOW_RGB;
        underflow_d = (underflow_q & ~underflow_clr) | (pix_req & ~pix_valid);
    end

    // State, counters and pin registers.
    always_ff @(posedge PixelClk) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            de_q        <= ~DE_POL;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            rgb_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            de_q        <= de_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            rgb_q       <= rgb_d;
            underflow_q <= underflow_d;
        end
    end

    assign underflow = underflow_q;
    assign LCD_DE    = de_q;
    assign LCD_HSYNC = hs_q;
    assign LCD_VSYNC = vs_q;
    assign LCD_R     = rgb_q[PIX_W-1 -: R_W];
    assign LCD_G     = rgb_q[B_W +: G_W];
    assign LCD_B     = rgb_q[B_W-1:0];

endmodule
